// File: rtl/speck128_encrypt_ctrl_if.sv
// Host-side bus of the SPECK128/128 encryption engine: request strobe, key/block in, result out.
// Handshake: start is a one-cycle request accepted only in IDLE or in DONE once finished=1;
// ciphertext is valid exactly while finished=1 and stays held until the next completion.
interface speck128_encrypt_ctrl_if;
  logic         start;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic [127:0] ciphertext;
  logic         finished;
  logic [4:0]   state_response;

  modport master (
    output start, key, plaintext,
    input  ciphertext, finished, state_response
  );

  modport slave (
    input  start, key, plaintext,
    output ciphertext, finished, state_response
  );
endinterface

// File: rtl/speck128_encrypt_ctrl.sv
// Iterative SPECK128/128 encryption: one round per clock with on-the-fly key schedule,
// wrapped in a small IDLE/LOAD/ROUND/DONE controller whose state is exported for debug.
module speck128_encrypt_ctrl #(
  parameter int ROUNDS = 32,
  parameter int WORD   = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  speck128_encrypt_ctrl_if.slave bus
);

  typedef enum logic [4:0] {
    IDLE  = 5'd0,
    LOAD  = 5'd1,
    ROUND = 5'd2,
    DONE  = 5'd3
  } state_t;

  state_t            state;
  logic [WORD-1:0]   x, y, k, l;
  logic [WORD-1:0]   x_nxt, y_nxt, k_nxt, l_nxt;
  logic [4:0]        rnd;
  logic [2*WORD-1:0] ct;
  logic              fin;

  // One round of the data path and the key schedule; the key schedule reuses the
  // round counter as its round constant.
  always_comb begin
    x_nxt = ({x[7:0], x[WORD-1:8]} + y) ^ k;
    y_nxt = {y[WORD-4:0], y[WORD-1:WORD-3]} ^ x_nxt;
    l_nxt = ({l[7:0], l[WORD-1:8]} + k) ^ WORD'(rnd);
    k_nxt = {k[WORD-4:0], k[WORD-1:WORD-3]} ^ l_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      k     <= '0;
      l     <= '0;
      rnd   <= '0;
      ct    <= '0;
      fin   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fin <= 1'b0;
          if (bus.start) state <= LOAD;
        end
        LOAD: begin
          x     <= bus.plaintext[2*WORD-1:WORD];
          y     <= bus.plaintext[WORD-1:0];
          l     <= bus.key[2*WORD-1:WORD];
          k     <= bus.key[WORD-1:0];
          rnd   <= '0;
          state <= ROUND;
        end
        ROUND: begin
          x   <= x_nxt;
          y   <= y_nxt;
          l   <= l_nxt;
          k   <= k_nxt;
          rnd <= rnd + 5'd1;
          if (rnd == 5'(ROUNDS - 1)) state <= DONE;
        end
        DONE: begin
          // First DONE cycle publishes the result; a new request is honoured only after that.
          if (!fin) begin
            ct  <= {x, y};
            fin <= 1'b1;
          end else if (bus.start) begin
            fin   <= 1'b0;
            state <= LOAD;
          end
        end
        default: begin
          fin   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ciphertext     = ct;
  assign bus.finished       = fin;
  assign bus.state_response = state;

endmodule

// File: tb/tb_speck128_encrypt_ctrl.sv
// Directed and randomized checks of speck128_encrypt_ctrl against a software SPECK128/128 model.
module tb_speck128_encrypt_ctrl;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  speck128_encrypt_ctrl_if bus ();

  speck128_encrypt_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] KEY1 = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] PT1  = 128'h6c61766975716520_7469206564616d20;
  localparam logic [127:0] CT1  = 128'ha65d985179783265_7860fedf5c570d18;
  localparam logic [127:0] KEY2 = 128'h753778214125442A_472D4B6150645367;
  localparam logic [127:0] PT2  = 128'he5b2862a6a7d27f3_cf1688b3fbc40c13;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] rol64(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  // Reference cipher: expand the full round-key schedule first, then run the rounds.
  function automatic logic [127:0] speck_ref(input logic [127:0] kin, input logic [127:0] pin);
    logic [63:0] ks[32];
    logic [63:0] lw, xw, yw;
    ks[0] = kin[63:0];
    lw    = kin[127:64];
    for (int i = 0; i < 31; i++) begin
      lw      = (ror64(lw, 8) + ks[i]) ^ 64'(i);
      ks[i+1] = rol64(ks[i], 3) ^ lw;
    end
    xw = pin[127:64];
    yw = pin[63:0];
    for (int i = 0; i < 32; i++) begin
      xw = (ror64(xw, 8) + yw) ^ ks[i];
      yw = rol64(yw, 3) ^ xw;
    end
    return {xw, yw};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one start pulse and follows the run to completion (bounded), checking latency and result.
  task automatic do_encrypt(input logic [127:0] k, input logic [127:0] p,
                            input bit trace, input bit busy_pulses);
    logic [127:0] exp_ct;
    int           lat;
    bit           done;
    exp_ct = speck_ref(k, p);
    bus.key       = k;
    bus.plaintext = p;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("load_state", bus.state_response, 128'd1);
    check("load_finished", bus.finished, 128'd0);
    lat  = 0;
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        bus.key       = rand128();
        bus.plaintext = rand128();
      end
      bus.start = busy_pulses && (c == 6 || c == 21);
      if (trace && c <= 33) check("trace_state", bus.state_response, (c <= 32) ? 128'd2 : 128'd3);
      if (bus.finished) begin
        done = 1'b1;
        lat  = c;
      end
    end
    bus.start = 1'b0;
    check("latency", lat, 128'd34);
    check("ciphertext", bus.ciphertext, exp_ct);
    check("done_state", bus.state_response, 128'd3);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.key       = '0;
    bus.plaintext = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", bus.state_response, 128'd0);
    check("reset_finished", bus.finished, 128'd0);
    check("reset_ciphertext", bus.ciphertext, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_state", bus.state_response, 128'd0);

    // Published vector with full state trace and busy-time start pulses.
    check("model_vector", speck_ref(KEY1, PT1), CT1);
    do_encrypt(KEY1, PT1, 1'b1, 1'b1);
    check("published_ct", bus.ciphertext, CT1);

    // Result holds while the inputs wander.
    for (int c = 0; c < 20; c++) begin
      bus.key       = rand128();
      bus.plaintext = rand128();
      @(posedge clk); #1;
      check("hold_ct", bus.ciphertext, CT1);
      check("hold_finished", bus.finished, 128'd1);
      check("hold_state", bus.state_response, 128'd3);
    end

    // Asynchronous reset in the middle of round 10.
    bus.key       = KEY1;
    bus.plaintext = PT1;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_state", bus.state_response, 128'd0);
    check("midreset_finished", bus.finished, 128'd0);
    check("midreset_ct", bus.ciphertext, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_encrypt(KEY1, PT1, 1'b1, 1'b0);
    check("rerun_ct", bus.ciphertext, CT1);

    // Back-to-back request straight from DONE.
    do_encrypt(KEY2, PT2, 1'b0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      do_encrypt(rand128(), rand128(), 1'b0, n[0]);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        check("idle_gap_ct_hold", bus.finished, 128'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
